// File: rtl/survival_time_counter_pkg.sv
// Shared asteroid-game definitions: FSM encoding, BCD digit width and the
// survival-time ceiling used by the score counter.
package survival_time_counter_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        PAUSED = 2'd2,
        OVER   = 2'd3
    } game_state_t;

    localparam int BCD_W       = 4;
    localparam int MAX_SECONDS = 999;

    // Binary value of a 3-digit {hundreds, tens, ones} BCD word.
    function automatic logic [31:0] bcd_value(input logic [3*BCD_W-1:0] bcd);
        return (32'(bcd[11:8]) * 32'd100) + (32'(bcd[7:4]) * 32'd10) + 32'(bcd[3:0]);
    endfunction

endpackage

// File: rtl/survival_time_counter_bcd_digit_counter.sv
// One decimal digit of the survival-time score: counts 0..9 on inc and
// produces a ripple carry for the next more significant digit.
module bcd_digit_counter
    import survival_time_counter_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             inc,
    input  logic             hold,
    output logic [BCD_W-1:0] digit,
    output logic             carry
);

    logic [BCD_W-1:0] digit_r;
    logic             at_nine_s;

    assign at_nine_s = (digit_r == 4'd9);
    assign carry     = inc & ~hold & at_nine_s;
    assign digit     = digit_r;

    // Digit register: clear wins, hold freezes the saturated score.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            digit_r <= 4'd0;
        end else if (clr) begin
            digit_r <= 4'd0;
        end else if (inc && !hold) begin
            digit_r <= at_nine_s ? 4'd0 : (digit_r + 4'd1);
        end else begin
            digit_r <= digit_r;
        end
    end

endmodule

// File: rtl/survival_time_counter.sv
// Survival-time counter: gates the one-second timer, counts its timeout
// pulses as BCD seconds and raises the difficulty level periodically.
module survival_time_counter
    import survival_time_counter_pkg::*;
#(
    parameter int LEVEL_PERIOD = 10,
    parameter int MAX_LEVEL    = 7,
    parameter int LEVEL_W      = 3
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    input  logic               pause,
    input  logic               collision,
    input  logic               tick,
    output logic               timer_enable,
    output logic [11:0]        secs_bcd,
    output logic [LEVEL_W-1:0] level,
    output logic               level_up,
    output logic               running,
    output logic               game_over
);

    localparam int PERIOD_W = 7;
    localparam logic [PERIOD_W-1:0] PERIOD_LAST = PERIOD_W'(LEVEL_PERIOD - 1);
    localparam logic [LEVEL_W-1:0]  LEVEL_MAX   = LEVEL_W'(MAX_LEVEL);

    game_state_t         state_r;
    game_state_t         state_n;
    logic                new_game_s;
    logic                sat_s;
    logic                count_s;
    logic [PERIOD_W-1:0] period_r;
    logic [LEVEL_W-1:0]  level_r;
    logic                level_up_r;
    logic                timer_enable_r;
    logic                running_r;
    logic                game_over_r;
    logic [BCD_W-1:0]    ones_s;
    logic [BCD_W-1:0]    tens_s;
    logic [BCD_W-1:0]    hund_s;
    logic                ones_carry_s;
    logic                tens_carry_s;
    logic                hund_carry_s;

    assign secs_bcd     = {hund_s, tens_s, ones_s};
    assign sat_s        = (bcd_value(secs_bcd) == 32'(MAX_SECONDS));
    // collision outranks start, so a simultaneous hit never restarts the game
    assign new_game_s   = ((state_r == IDLE) || (state_r == OVER)) && start && !collision;
    assign count_s      = (state_r == RUN) && tick && !collision && !pause && !sat_s;

    // Next-state logic.
    always_comb begin
        state_n = state_r;
        case (state_r)
            IDLE: begin
                if (new_game_s) state_n = RUN;
                else            state_n = IDLE;
            end
            RUN: begin
                if (collision)  state_n = OVER;
                else if (pause) state_n = PAUSED;
                else            state_n = RUN;
            end
            PAUSED: begin
                if (collision)   state_n = OVER;
                else if (!pause) state_n = RUN;
                else             state_n = PAUSED;
            end
            OVER: begin
                if (new_game_s) state_n = RUN;
                else            state_n = OVER;
            end
            default: state_n = IDLE;
        endcase
    end

    // State register and status outputs, registered from the next state.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r        <= IDLE;
            timer_enable_r <= 1'b0;
            running_r      <= 1'b0;
            game_over_r    <= 1'b0;
        end else begin
            state_r        <= state_n;
            timer_enable_r <= (state_n == RUN);
            running_r      <= (state_n == RUN);
            game_over_r    <= (state_n == OVER);
        end
    end

    // Level-period counter, level and its one-cycle increment pulse.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            period_r   <= 7'd0;
            level_r    <= '0;
            level_up_r <= 1'b0;
        end else if (new_game_s) begin
            period_r   <= 7'd0;
            level_r    <= '0;
            level_up_r <= 1'b0;
        end else if (count_s) begin
            if (period_r == PERIOD_LAST) begin
                period_r <= 7'd0;
                if (level_r < LEVEL_MAX) begin
                    level_r    <= level_r + 1'b1;
                    level_up_r <= 1'b1;
                end else begin
                    level_r    <= level_r;
                    level_up_r <= 1'b0;
                end
            end else begin
                period_r   <= period_r + 7'd1;
                level_r    <= level_r;
                level_up_r <= 1'b0;
            end
        end else begin
            period_r   <= period_r;
            level_r    <= level_r;
            level_up_r <= 1'b0;
        end
    end

    bcd_digit_counter u_ones (
        .clk   (clk),
        .rst   (rst),
        .clr   (new_game_s),
        .inc   (count_s),
        .hold  (sat_s),
        .digit (ones_s),
        .carry (ones_carry_s)
    );

    bcd_digit_counter u_tens (
        .clk   (clk),
        .rst   (rst),
        .clr   (new_game_s),
        .inc   (ones_carry_s),
        .hold  (sat_s),
        .digit (tens_s),
        .carry (tens_carry_s)
    );

    bcd_digit_counter u_hund (
        .clk   (clk),
        .rst   (rst),
        .clr   (new_game_s),
        .inc   (tens_carry_s),
        .hold  (sat_s),
        .digit (hund_s),
        .carry (hund_carry_s)
    );

    assign timer_enable = timer_enable_r;
    assign running      = running_r;
    assign game_over    = game_over_r;
    assign level        = level_r;
    assign level_up     = level_up_r;

    logic unused_s;
    assign unused_s = hund_carry_s;

endmodule

// File: tb/tb_survival_time_counter.sv
// Directed bench for survival_time_counter with hand-computed expectations.
module tb_survival_time_counter;

    logic        clk;
    logic        rst;
    logic        start;
    logic        pause;
    logic        collision;
    logic        tick;
    logic        timer_enable;
    logic [11:0] secs_bcd;
    logic [2:0]  level;
    logic        level_up;
    logic        running;
    logic        game_over;

    int total_cnt;
    int bad_cnt;
    int lu_cnt;

    survival_time_counter #(
        .LEVEL_PERIOD (10),
        .MAX_LEVEL    (7),
        .LEVEL_W      (3)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .pause        (pause),
        .collision    (collision),
        .tick         (tick),
        .timer_enable (timer_enable),
        .secs_bcd     (secs_bcd),
        .level        (level),
        .level_up     (level_up),
        .running      (running),
        .game_over    (game_over)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total_cnt++;
        if (obs !== exp) begin
            bad_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check_reset_outputs(input string tag);
        check_val({tag, "_secs"}, 32'(secs_bcd), 32'h000);
        check_val({tag, "_level"}, 32'(level), 32'd0);
        check_val({tag, "_lu"}, 32'(level_up), 32'd0);
        check_val({tag, "_te"}, 32'(timer_enable), 32'd0);
        check_val({tag, "_run"}, 32'(running), 32'd0);
        check_val({tag, "_over"}, 32'(game_over), 32'd0);
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic ticks(input int n);
        tick = 1'b1;
        repeat (n) step();
        tick = 1'b0;
    endtask

    initial begin
        total_cnt = 0;
        bad_cnt   = 0;
        lu_cnt    = 0;
        rst       = 1'b0;
        start     = 1'b0;
        pause     = 1'b0;
        collision = 1'b0;
        tick      = 1'b0;

        #12;
        check_reset_outputs("reset");
        step();
        rst = 1'b1;
        step();
        check_val("idle_run", 32'(running), 32'd0);

        pulse_start();
        check_val("start_run", 32'(running), 32'd1);
        check_val("start_te", 32'(timer_enable), 32'd1);
        check_val("start_secs", 32'(secs_bcd), 32'h000);
        check_val("start_level", 32'(level), 32'd0);

        // 25 ticks spaced by an idle cycle; level_up follows ticks 10 and 20 only
        for (int i = 1; i <= 25; i++) begin
            tick = 1'b1;
            step();
            tick = 1'b0;
            check_val($sformatf("lu_tick%0d", i), 32'(level_up), ((i == 10) || (i == 20)) ? 32'd1 : 32'd0);
            if (level_up) lu_cnt++;
            step();
            check_val($sformatf("lu_gap%0d", i), 32'(level_up), 32'd0);
        end
        check_val("run25_secs", 32'(secs_bcd), 32'h025);
        check_val("run25_level", 32'(level), 32'd2);
        check_val("run25_lu_count", 32'(lu_cnt), 32'd2);

        // pause swallows ticks and drops the timer enable
        pause = 1'b1;
        step();
        check_val("pause_te", 32'(timer_enable), 32'd0);
        check_val("pause_run", 32'(running), 32'd0);
        for (int i = 0; i < 5; i++) begin
            tick = 1'b1;
            step();
            tick = 1'b0;
            check_val("pause_te_hold", 32'(timer_enable), 32'd0);
        end
        pause = 1'b0;
        step();
        check_val("resume_te", 32'(timer_enable), 32'd1);
        check_val("resume_secs", 32'(secs_bcd), 32'h025);
        ticks(1);
        check_val("resume_tick_secs", 32'(secs_bcd), 32'h026);

        collision = 1'b1;
        step();
        collision = 1'b0;
        check_val("hit_over", 32'(game_over), 32'd1);
        check_val("hit_te", 32'(timer_enable), 32'd0);
        ticks(1);
        check_val("over_frozen", 32'(secs_bcd), 32'h026);

        // collision outranks start while already OVER
        start     = 1'b1;
        collision = 1'b1;
        step();
        start     = 1'b0;
        collision = 1'b0;
        check_val("over_start_hit", 32'(game_over), 32'd1);
        check_val("over_start_hit_secs", 32'(secs_bcd), 32'h026);

        pulse_start();
        check_val("restart_secs", 32'(secs_bcd), 32'h000);
        check_val("restart_run", 32'(running), 32'd1);

        // collision coincident with a tick at 9 seconds
        ticks(9);
        check_val("pre_hit_secs", 32'(secs_bcd), 32'h009);
        collision = 1'b1;
        tick      = 1'b1;
        step();
        collision = 1'b0;
        tick      = 1'b0;
        check_val("hit_tick_over", 32'(game_over), 32'd1);
        check_val("hit_tick_secs", 32'(secs_bcd), 32'h009);
        check_val("hit_tick_te", 32'(timer_enable), 32'd0);
        pulse_start();
        check_val("hit_restart_secs", 32'(secs_bcd), 32'h000);
        check_val("hit_restart_run", 32'(running), 32'd1);

        // carry chain and saturation
        ticks(998);
        check_val("sat998_secs", 32'(secs_bcd), 32'h998);
        check_val("sat998_level", 32'(level), 32'd7);
        ticks(1);
        check_val("sat999_secs", 32'(secs_bcd), 32'h999);
        for (int i = 0; i < 2; i++) begin
            ticks(1);
            check_val("sat_hold_secs", 32'(secs_bcd), 32'h999);
            check_val("sat_hold_lu", 32'(level_up), 32'd0);
            check_val("sat_hold_level", 32'(level), 32'd7);
        end

        // asynchronous reset in the middle of a game at 57 s, level 5
        collision = 1'b1;
        step();
        collision = 1'b0;
        pulse_start();
        ticks(57);
        check_val("pre_rst_secs", 32'(secs_bcd), 32'h057);
        check_val("pre_rst_level", 32'(level), 32'd5);
        #2;
        rst = 1'b0;
        #1;
        check_reset_outputs("async_rst");
        step();
        rst = 1'b1;
        step();
        pulse_start();
        check_val("post_rst_run", 32'(running), 32'd1);
        check_val("post_rst_secs", 32'(secs_bcd), 32'h000);
        ticks(1);
        check_val("post_rst_tick", 32'(secs_bcd), 32'h001);

        $display("test done: total=%0d bad=%0d", total_cnt, bad_cnt);
        $finish;
    end

endmodule
